// File: rtl/button_event_fsm_if.sv
// rtl/button_event_fsm_if.sv - button level in, classified event pulses out
//   pressed      : debounced, synchronised button level (1 = held)
//   short_pulse  : one-cycle pulse, single short press confirmed
//   double_pulse : one-cycle pulse, second press of a double click
//   long_pulse   : one-cycle pulse, hold reached the long threshold
//   busy         : classifier is in the middle of a gesture
interface button_event_fsm_if;
  logic pressed;
  logic short_pulse;
  logic double_pulse;
  logic long_pulse;
  logic busy;

  modport master (
    output pressed,
    input  short_pulse,
    input  double_pulse,
    input  long_pulse,
    input  busy
  );

  modport slave (
    input  pressed,
    output short_pulse,
    output double_pulse,
    output long_pulse,
    output busy
  );
endinterface

// File: rtl/button_event_fsm.sv
// rtl/button_event_fsm.sv - classifies button presses into short/double/long event pulses
//   clk   : system clock, all state changes on rising edge
//   reset : asynchronous active-low reset
//   bus   : slave side of button_event_fsm_if (pressed in, pulses and busy out)
module button_event_fsm #(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int DCLICK_CYCLES = 25_000_000,
  parameter int CNT_BITS      = 27
) (
  input  logic                clk,
  input  logic                reset,
  button_event_fsm_if.slave   bus
);

  if (LONG_CYCLES < 2) begin : g_bad_long
    $error("button_event_fsm: LONG_CYCLES must be >= 2");
  end
  if (DCLICK_CYCLES < 2) begin : g_bad_dclick
    $error("button_event_fsm: DCLICK_CYCLES must be >= 2");
  end
  if ((longint'(LONG_CYCLES) >= (longint'(1) << CNT_BITS)) ||
      (longint'(DCLICK_CYCLES) >= (longint'(1) << CNT_BITS))) begin : g_bad_width
    $error("button_event_fsm: CNT_BITS too narrow for the cycle limits");
  end

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRESS    = 2'd1,
    ST_GAP      = 2'd2,
    ST_WAIT_REL = 2'd3
  } state_t;

  // Terminal counts: the counter already holds the number of samples seen,
  // so the Nth sample arrives while cnt equals N-1.
  localparam logic [CNT_BITS-1:0] CNT_ONE     = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] LONG_TERM   = CNT_BITS'(LONG_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] DCLICK_TERM = CNT_BITS'(DCLICK_CYCLES - 1);

  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                short_q, short_d;
  logic                double_q, double_d;
  logic                long_q, long_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      double_q <= double_d;
      long_q   <= long_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.pressed) begin
          state_d = ST_PRESS;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      ST_PRESS: begin
        if (bus.pressed) begin
          if (cnt_q == LONG_TERM) begin
            long_d  = 1'b1;
            state_d = ST_WAIT_REL;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
          end
        end else begin
          state_d = ST_GAP;
          cnt_d   = CNT_ONE;
        end
      end
      ST_GAP: begin
        // A press in the gap wins over the terminal count: it is always a
        // double click, and WAIT_REL swallows any long hold that follows.
        if (bus.pressed) begin
          double_d = 1'b1;
          state_d  = ST_WAIT_REL;
        end else if (cnt_q == DCLICK_TERM) begin
          short_d  = 1'b1;
          state_d  = ST_IDLE;
          cnt_d    = '0;
        end else begin
          cnt_d    = cnt_q + CNT_ONE;
        end
      end
      ST_WAIT_REL: begin
        if (!bus.pressed) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.short_pulse  = short_q;
  assign bus.double_pulse = double_q;
  assign bus.long_pulse   = long_q;
  assign bus.busy         = (state_q != ST_IDLE);

endmodule

// File: doc/button_event_fsm.md
# button_event_fsm

Classifies presses of one debounced push-button into single-cycle event pulses: short press, double click and long press. It sits directly downstream of the two-flop synchroniser plus `debounce` front end and consumes its `clean` level. Its pulses replace the simple rising-edge toggle as the trigger for LED and mode logic. All timing is in `clk` cycles, set by parameters, so the bench can run short values.

## Interface
- `LONG_CYCLES`, default 50_000_000: consecutive high samples that make a long press; legal range ≥ 2.
- `DCLICK_CYCLES`, default 25_000_000: consecutive low samples after a release that close the double-click window; legal range ≥ 2.
- `CNT_BITS`, default 27: width of the shared cycle counter; must hold max(`LONG_CYCLES`, `DCLICK_CYCLES`).
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset, 1 = run).
- `pressed`  in  1  debounced, synchronised button level (1 = held).
- `short_pulse`  out  1  one-cycle pulse when a single short press is confirmed.
- `double_pulse`  out  1  one-cycle pulse on the second press of a double click.
- `long_pulse`  out  1  one-cycle pulse when a hold reaches `LONG_CYCLES`.
- `busy`  out  1  high whenever the FSM is not in IDLE (combinational decode of the state).

## Operation
- The FSM has four states. `cnt` is `CNT_BITS` wide and shared between states.
- **IDLE**: if `pressed`=1, go to PRESS and set `cnt`←1. Otherwise stay, with `cnt`←0.
- **PRESS**: counts high samples.
  - `pressed`=1 and `cnt`=`LONG_CYCLES`−1: set `long_pulse`←1 and go to WAIT_REL.
  - `pressed`=1 otherwise: `cnt`←`cnt`+1.
  - `pressed`=0: go to GAP with `cnt`←1.
- **GAP**: counts low samples after the first release.
  - `pressed`=1: set `double_pulse`←1 and go to WAIT_REL.
  - `pressed`=0 and `cnt`=`DCLICK_CYCLES`−1: set `short_pulse`←1 and go to IDLE.
  - Otherwise: `cnt`←`cnt`+1.
- **WAIT_REL**: absorbs the rest of a long hold or the second press. No events are produced here. `pressed`=0 returns to IDLE with `cnt`←0.
- There is exactly one event per gesture, and the three pulses are mutually exclusive.
- A press that starts in GAP is always a double click, even if it is later held beyond `LONG_CYCLES`. No long pulse follows it.
- Counter wrap-around cannot occur, because every counting state leaves at its terminal count. Parameter limits are checked by elaboration-time assertion.
- A third fast press after a double click starts a new gesture from IDLE.

## Timing
- Reset asserted (`reset`=0) takes effect asynchronously:
  - state=IDLE, `cnt`=0;
  - `short_pulse`=`double_pulse`=`long_pulse`=0;
  - `busy`=0.
  - This applies mid-gesture as well: any pending event is discarded and no pulse is emitted.
- Reset deassertion is synchronous to `clk` upstream. The first active edge samples `pressed`. If the button is already held at that edge, the hold counts as a new press.
- Pulse outputs are registered and high for exactly one cycle.
- Long press: let the first edge sampling `pressed`=1 be e0. `long_pulse` goes high after edge e(`LONG_CYCLES`−1) and low after the next edge.
  - A release sampled at edge e(`LONG_CYCLES`−1) or earlier is a short or double candidate, never a long press.
- Short press: `short_pulse` goes high after the `DCLICK_CYCLES`-th consecutive low sample following the release.
- Double click: `double_pulse` goes high one edge after the second press is first sampled. Latency is 1 cycle.
- `busy` rises in the cycle after the first high sample. It falls in the same cycle as `short_pulse`, or in the cycle after release is sampled in WAIT_REL.

## Test plan
Bench parameters: `LONG_CYCLES`=8, `DCLICK_CYCLES`=4.
1. Hold `reset`=0 for 3 cycles with `pressed` toggling, then release → all outputs stay 0 and `busy`=0.
2. `pressed`=1 for 3 cycles, then 0 → exactly one `short_pulse`, 4 cycles after the first low sample; no other pulses; then `busy`=0.
3. `pressed`=1 for 3 cycles, 0 for 2 cycles, 1 for 3 cycles, then 0 → one `double_pulse`, 1 cycle after the second rise; no `short_pulse`.
4. `pressed`=1 for 20 cycles → one `long_pulse` after the 8th high sample; nothing more until release; `busy` drops 1 cycle after release.
5. `pressed`=1 for exactly 7 cycles, then 0 for 4 → `short_pulse` only; `long_pulse` never asserts (boundary).
6. `pressed`=1 for 3 cycles, 0 for 1, then `reset`=0 during GAP → no pulse, state IDLE, `busy`=0 immediately. A subsequent 3-high/4-low gesture yields one `short_pulse`.
